// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_pkg
//  Description : Shared state encoding and default widths for reg_bus_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_bus_pkg;

    localparam int c_def_addr_w = 6;
    localparam int c_def_data_w = 8;
    localparam int c_state_w    = 2;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_issue   = 2'd1;
    localparam state_t c_st_rd_wait = 2'd2;
    localparam state_t c_st_ack     = 2'd3;

    // Width of an index/counter able to hold 0..n-1, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin pick: first valid request at or
//                after ptr, as one-hot grant plus binary index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_select #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_ofs;
    logic [IDX_W:0]     w_sum;

    // Rotate so that the requester at ptr sits at bit 0.
    assign w_rot     = NUM_REQ'({req, req} >> ptr);
    assign any_valid = |req;

    always_comb begin
        w_ofs = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_ofs = IDX_W'(k);
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_ofs};
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
    end

    assign idx = w_sum[IDX_W-1:0];

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any_valid && (idx == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_arbiter
//  Description : Round-robin arbiter giving several requesters one-at-a-time
//                access to a register file with a fixed read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int RD_LAT  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         address,
    output logic                      write_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      read_en,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int c_idx_w = idx_width(NUM_REQ);
    localparam int c_cnt_w = idx_width(RD_LAT);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [c_idx_w-1:0]  w_idx;
    logic                w_any;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_select (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .idx       (w_idx),
        .any_valid (w_any)
    );

    // One-hot AND-OR mux of the winning requester's command.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (w_any) w_next = c_st_issue;
            c_st_issue:   w_next = r_we ? c_st_ack : c_st_rd_wait;
            c_st_rd_wait: if (r_cnt == c_cnt_last) w_next = c_st_ack;
            c_st_ack:     w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_win   <= w_idx;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                    end
                end
                c_st_issue: r_cnt <= '0;
                c_st_rd_wait: begin
                    if (r_cnt == c_cnt_last) begin
                        r_rdata <= rd_data;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_ack: r_rr_ptr <= (r_win == c_last_idx) ? '0 : r_win + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != c_st_idle);
        write_en = 1'b0;
        read_en  = 1'b0;
        address  = '0;
        wr_data  = '0;
        req_ack  = '0;
        case (r_state)
            c_st_issue: begin
                write_en = r_we;
                read_en  = ~r_we;
                address  = r_addr;
                wr_data  = r_wdata;
            end
            c_st_ack: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ack[i] = (r_win == c_idx_w'(i));
                end
            end
            default: ;
        endcase
    end

    assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire
